risc_exec_unit: RTL and testbench

Execute stage of the single-cycle 32-bit RISC core. It holds three parts:
- ALU operand selection, including the conditional-move (cmov) operand substitution.
- A 32-bit ALU with 16 operations.
- Branch/next-PC resolution.
It sits between the register bank/immediate path (upstream) and the data memory, write-back mux and program counter (downstream).

---
 rtl/risc_exec_unit.sv | 122 ++++++++++++
 tb/tb_risc_exec_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/risc_exec_unit.sv
// risc_exec_unit
//   Execute stage of the single-cycle 32-bit RISC core. It selects the ALU
//   operands, including the conditional-move substitution. It runs a
//   16-function ALU and resolves the branch condition. It registers the
//   next PC.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset (clears NPC only)
//   aluOp   in   [3:0]   ALU function select
//   brOp    in   [2:0]   branch op; brOp[2]=0 -> PC is operand 1, 1 -> A
//   aluSrc  in           operand 2 select: 0=imm, 1=B
//   isCmov  in           conditional move: result becomes signed min(A,B)
//   A       in   [N-1:0] rs value
//   B       in   [N-1:0] rt value
//   imm     in   [N-1:0] sign-extended immediate
//   PC      in   [N-1:0] current PC (word address)
//   alures  out  [N-1:0] combinational ALU result (address/wb/branch target)
//   NPC     out  [N-1:0] registered next PC
module risc_exec_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   aluOp,
    input  logic [2:0]   brOp,
    input  logic         aluSrc,
    input  logic         isCmov,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] imm,
    input  logic [N-1:0] PC,
    output logic [N-1:0] alures,
    output logic [N-1:0] NPC
);

    localparam int SHW = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Population count of a datapath word.
    function automatic logic [N-1:0] popcount(input logic [N-1:0] v);
        logic [N-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{(N-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    logic [N-1:0]        op1, op2, fin1, fin2;
    logic signed [N-1:0] a_s, b_s, x_s, y_s;
    logic [SHW-1:0]      shamt;
    logic                taken;
    logic [N-1:0]        npc_cand;

    assign a_s = A;
    assign b_s = B;

    // Operand selection. A cmov is issued as ADD, so forcing the second
    // operand to zero makes the ALU pass the smaller signed operand.
    always_comb begin
        op1  = brOp[2] ? A : PC;
        op2  = aluSrc ? B : imm;
        fin1 = op1;
        fin2 = op2;
        if (isCmov) begin
            fin1 = (a_s < b_s) ? A : B;
            fin2 = '0;
        end
    end

    assign x_s   = fin1;
    assign y_s   = fin2;
    assign shamt = fin2[SHW-1:0];

    // ALU. All arithmetic wraps modulo 2^N and overflow is not reported.
    always_comb begin
        alures = '0;
        case (aluOp)
            4'b0000: alures = fin1 + fin2;
            4'b0001: alures = fin1 - fin2;
            4'b0010: alures = fin1 & fin2;
            4'b0011: alures = fin1 | fin2;
            4'b0100: alures = fin1 ^ fin2;
            4'b0101: alures = ~fin1;
            4'b0110: alures = fin1 << shamt;
            4'b0111: alures = fin1 >> shamt;
            4'b1000: alures = x_s >>> shamt;
            4'b1001: alures = fin1 + ONE;
            4'b1010: alures = fin1 - ONE;
            4'b1011: alures = popcount(fin1);
            4'b1100: alures = (x_s < y_s) ? ONE : '0;
            4'b1101: alures = (x_s > y_s) ? ONE : '0;
            4'b1110: alures = fin2 << 16;
            default: alures = fin2;
        endcase
    end

    // Branch condition on A. Ops 1xx are ordinary sequential instructions.
    always_comb begin
        taken = 1'b0;
        case (brOp)
            3'b000:  taken = 1'b1;
            3'b001:  taken = A[N-1];
            3'b010:  taken = ~A[N-1];
            3'b011:  taken = (A == '0);
            default: taken = 1'b0;
        endcase
    end

    assign npc_cand = taken ? alures : PC + ONE;

    // Next-PC register. An asynchronous reset discards any pending update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            NPC <= '0;
        end else begin
            NPC <= npc_cand;
        end
    end

endmodule

// File: tb/tb_risc_exec_unit.sv
module tb_risc_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  aluOp;
    logic [2:0]  brOp;
    logic        aluSrc;
    logic        isCmov;
    logic [31:0] A, B, imm, PC;
    logic [31:0] alures, NPC;

    int errors = 0;
    int checks = 0;

    risc_exec_unit #(.N(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .aluOp  (aluOp),
        .brOp   (brOp),
        .aluSrc (aluSrc),
        .isCmov (isCmov),
        .A      (A),
        .B      (B),
        .imm    (imm),
        .PC     (PC),
        .alures (alures),
        .NPC    (NPC)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Settle after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] exp);
        aluOp = op;
        #1;
        chk(tag, alures, exp);
    endtask

    task automatic br(input string tag, input logic [2:0] bo, input logic [31:0] a,
                      input logic [31:0] exp);
        brOp = bo;
        A    = a;
        tick();
        chk(tag, NPC, exp);
    endtask

    initial begin
        rst    = 1'b0;
        aluOp  = 4'b0000;
        brOp   = 3'b100;
        aluSrc = 1'b1;
        isCmov = 1'b0;
        A      = '0;
        B      = '0;
        imm    = '0;
        PC     = '0;

        // Reset held across a clock edge keeps NPC at zero.
        #12;
        chk("reset_hold", NPC, 32'h0);

        // First update after release: PC+1.
        rst = 1'b1;
        PC  = 32'h0;
        tick();
        chk("first_after_reset", NPC, 32'h1);

        PC = 32'h0000000F;
        tick();
        chk("npc_seq_0x10", NPC, 32'h10);

        // Asynchronous reset between edges.
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset", NPC, 32'h0);
        tick();
        chk("reset_discards_update", NPC, 32'h0);
        #2;
        rst = 1'b1;

        // ALU sweep with register operands.
        brOp   = 3'b100;
        aluSrc = 1'b1;
        A      = 32'hF000000F;
        B      = 32'h00000004;
        alu("ADD",  4'b0000, 32'hF0000013);
        alu("SUB",  4'b0001, 32'hF000000B);
        alu("AND",  4'b0010, 32'h00000004);
        alu("OR",   4'b0011, 32'hF000000F);
        alu("XOR",  4'b0100, 32'hF000000B);
        alu("NOT",  4'b0101, 32'h0FFFFFF0);
        alu("SLL",  4'b0110, 32'h000000F0);
        alu("SRL",  4'b0111, 32'h0F000000);
        alu("SRA",  4'b1000, 32'hFF000000);
        alu("INC",  4'b1001, 32'hF0000010);
        alu("DEC",  4'b1010, 32'hF000000E);
        alu("HAM",  4'b1011, 32'h00000008);
        alu("SLT",  4'b1100, 32'h00000001);
        alu("SGT",  4'b1101, 32'h00000000);
        alu("LUI",  4'b1110, 32'h00040000);
        alu("PASS", 4'b1111, 32'h00000004);

        // Only the low five bits of the shift amount are used.
        B = 32'h00000024;
        alu("SLL_shamt_mask", 4'b0110, 32'h000000F0);
        A = 32'hFFFFFFFF;
        alu("HAM_all_ones", 4'b1011, 32'h00000020);
        A = 32'h7FFFFFFF;
        B = 32'h00000001;
        alu("ADD_overflow_wraps", 4'b0000, 32'h80000000);

        // Immediate path.
        aluSrc = 1'b0;
        imm    = 32'hFFFFFFFF;
        A      = 32'h5;
        alu("imm_add", 4'b0000, 32'h00000004);

        // Conditional move: signed minimum of A and B.
        aluSrc = 1'b1;
        isCmov = 1'b1;
        A = 32'hFFFFFFFD; B = 32'h7;
        alu("cmov_a_min", 4'b0000, 32'hFFFFFFFD);
        A = 32'h7; B = 32'hFFFFFFFD;
        alu("cmov_b_min", 4'b0000, 32'hFFFFFFFD);
        A = 32'h9; B = 32'h9;
        alu("cmov_equal", 4'b0000, 32'h00000009);
        isCmov = 1'b0;

        // Branches: target PC+imm = 0x20-8 = 0x18, fall-through 0x21.
        aluOp  = 4'b0000;
        aluSrc = 1'b0;
        PC     = 32'h20;
        imm    = 32'hFFFFFFF8;
        br("BR",        3'b000, 32'h00000000, 32'h18);
        br("BZ_taken",  3'b011, 32'h00000000, 32'h18);
        br("BZ_not",    3'b011, 32'h00000001, 32'h21);
        br("BMI_taken", 3'b001, 32'h80000000, 32'h18);
        br("BPL_not",   3'b010, 32'h80000000, 32'h21);
        br("BMI_not",   3'b001, 32'h00000001, 32'h21);
        br("BPL_taken", 3'b010, 32'h00000001, 32'h18);
        br("op111_seq", 3'b111, 32'h00000000, 32'h21);

        // PC+1 wraps.
        PC = 32'hFFFFFFFF;
        br("pc_wrap", 3'b100, 32'h00000000, 32'h00000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
